// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX bundle: control from ctrl, decode results from ID,
// registered copies to EX plus feedback and bubble statistics.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int EXC_W      = 32,
    parameter int CNT_W      = 16
);
    logic                  stall_id;
    logic                  stall_ex;
    logic                  flush;
    logic                  cnt_clr;

    logic [ALUOP_W-1:0]    id_aluop;
    logic [ALUSEL_W-1:0]   id_alusel;
    logic [DATA_W-1:0]     id_reg1;
    logic [DATA_W-1:0]     id_reg2;
    logic [REG_ADDR_W-1:0] id_wd;
    logic                  id_wreg;
    logic [DATA_W-1:0]     id_link_address;
    logic                  id_is_in_delayslot;
    logic                  next_inst_in_delayslot_i;
    logic [DATA_W-1:0]     id_inst;
    logic [DATA_W-1:0]     id_pc;
    logic [EXC_W-1:0]      id_excepttype;

    logic [ALUOP_W-1:0]    ex_aluop;
    logic [ALUSEL_W-1:0]   ex_alusel;
    logic [DATA_W-1:0]     ex_reg1;
    logic [DATA_W-1:0]     ex_reg2;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_link_address;
    logic                  ex_is_in_delayslot;
    logic [DATA_W-1:0]     ex_inst;
    logic [DATA_W-1:0]     ex_pc;
    logic [EXC_W-1:0]      ex_excepttype;
    logic                  ex_valid;
    logic                  is_in_delayslot_o;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output stall_id, stall_ex, flush, cnt_clr,
        output id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        output id_link_address, id_is_in_delayslot,
        output next_inst_in_delayslot_i, id_inst, id_pc, id_excepttype,
        input  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        input  ex_link_address, ex_is_in_delayslot, ex_inst, ex_pc,
        input  ex_excepttype, ex_valid, is_in_delayslot_o, bubble_cnt
    );

    modport slave (
        input  stall_id, stall_ex, flush, cnt_clr,
        input  id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        input  id_link_address, id_is_in_delayslot,
        input  next_inst_in_delayslot_i, id_inst, id_pc, id_excepttype,
        output ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        output ex_link_address, ex_is_in_delayslot, ex_inst, ex_pc,
        output ex_excepttype, ex_valid, is_in_delayslot_o, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, bubble insertion, flush,
// valid bit, delay-slot feedback and a saturating stall-bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int EXC_W      = 32,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    id_ex_pipe_reg_if.slave  bus
);
    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
        logic [DATA_W-1:0]     reg1;
        logic [DATA_W-1:0]     reg2;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     link;
        logic                  dly;
        logic [DATA_W-1:0]     inst;
        logic [DATA_W-1:0]     pc;
        logic [EXC_W-1:0]      exc;
        logic                  valid;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_t             ex_q, ex_d, id_pkt;
    logic            dly_q, dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            do_flush, do_hold, do_bubble, do_adv;

    assign do_flush  = bus.flush;
    assign do_hold   = !bus.flush && bus.stall_ex;
    assign do_bubble = !bus.flush && !bus.stall_ex && bus.stall_id;
    assign do_adv    = !bus.flush && !bus.stall_ex && !bus.stall_id;

    always_comb begin
        id_pkt        = '0;
        id_pkt.aluop  = bus.id_aluop;
        id_pkt.alusel = bus.id_alusel;
        id_pkt.reg1   = bus.id_reg1;
        id_pkt.reg2   = bus.id_reg2;
        id_pkt.wd     = bus.id_wd;
        id_pkt.wreg   = bus.id_wreg;
        id_pkt.link   = bus.id_link_address;
        id_pkt.dly    = bus.id_is_in_delayslot;
        id_pkt.inst   = bus.id_inst;
        id_pkt.pc     = bus.id_pc;
        id_pkt.exc    = bus.id_excepttype;
        id_pkt.valid  = 1'b1;
    end

    // NOP codes are all zero, so a bubble is simply an all-zero packet
    always_comb begin
        ex_d  = ex_q;
        dly_d = dly_q;
        cnt_d = cnt_q;
        unique case (1'b1)
            do_flush: begin
                ex_d  = '0;
                dly_d = 1'b0;
            end
            do_hold: begin
                ex_d  = ex_q;
            end
            do_bubble: begin
                ex_d  = '0;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end
            do_adv: begin
                ex_d  = id_pkt;
                dly_d = bus.next_inst_in_delayslot_i;
            end
            default: ;
        endcase
        if (bus.cnt_clr) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            dly_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            dly_q <= dly_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_aluop           = ex_q.aluop;
    assign bus.ex_alusel          = ex_q.alusel;
    assign bus.ex_reg1            = ex_q.reg1;
    assign bus.ex_reg2            = ex_q.reg2;
    assign bus.ex_wd              = ex_q.wd;
    assign bus.ex_wreg            = ex_q.wreg;
    assign bus.ex_link_address    = ex_q.link;
    assign bus.ex_is_in_delayslot = ex_q.dly;
    assign bus.ex_inst            = ex_q.inst;
    assign bus.ex_pc              = ex_q.pc;
    assign bus.ex_excepttype      = ex_q.exc;
    assign bus.ex_valid           = ex_q.valid;
    assign bus.is_in_delayslot_o  = dly_q;
    assign bus.bubble_cnt         = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: default instance plus a
// CNT_W=2 instance for counter saturation.
module tb_id_ex_pipe_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg_if                b0 ();
    id_ex_pipe_reg_if #(.CNT_W(2))   b1 ();

    id_ex_pipe_reg u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    id_ex_pipe_reg #(.CNT_W(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        b0.stall_id = 0; b0.stall_ex = 0; b0.flush = 0; b0.cnt_clr = 0;
        b0.id_aluop = '0; b0.id_alusel = '0;
        b0.id_reg1 = '0; b0.id_reg2 = '0;
        b0.id_wd = '0; b0.id_wreg = 0;
        b0.id_link_address = '0; b0.id_is_in_delayslot = 0;
        b0.next_inst_in_delayslot_i = 0;
        b0.id_inst = '0; b0.id_pc = '0; b0.id_excepttype = '0;
        b1.stall_id = 0; b1.stall_ex = 0; b1.flush = 0; b1.cnt_clr = 0;
        b1.id_aluop = '0; b1.id_alusel = '0;
        b1.id_reg1 = '0; b1.id_reg2 = '0;
        b1.id_wd = '0; b1.id_wreg = 0;
        b1.id_link_address = '0; b1.id_is_in_delayslot = 0;
        b1.next_inst_in_delayslot_i = 0;
        b1.id_inst = '0; b1.id_pc = '0; b1.id_excepttype = '0;
    endtask

    initial begin
        zero_inputs();
        tick();
        tick();
        chk("rst_valid", 64'(b0.ex_valid), 64'd0);
        chk("rst_aluop", 64'(b0.ex_aluop), 64'd0);
        chk("rst_dly_o", 64'(b0.is_in_delayslot_o), 64'd0);
        chk("rst_cnt", 64'(b0.bubble_cnt), 64'd0);

        // advance
        rst = 1;
        b0.id_aluop = 8'h21; b0.id_reg1 = 32'h1234_5678;
        b0.id_wd = 5'd3; b0.id_wreg = 1; b0.id_alusel = 3'd5;
        b0.id_pc = 32'h0000_0100; b0.id_excepttype = 32'h8;
        b0.id_is_in_delayslot = 1; b0.next_inst_in_delayslot_i = 1;
        b0.id_link_address = 32'h0000_0108; b0.id_inst = 32'h8c41_0004;
        tick();
        chk("adv_aluop", 64'(b0.ex_aluop), 64'h21);
        chk("adv_reg1", 64'(b0.ex_reg1), 64'h1234_5678);
        chk("adv_wd", 64'(b0.ex_wd), 64'd3);
        chk("adv_wreg", 64'(b0.ex_wreg), 64'd1);
        chk("adv_valid", 64'(b0.ex_valid), 64'd1);
        chk("adv_alusel", 64'(b0.ex_alusel), 64'd5);
        chk("adv_pc", 64'(b0.ex_pc), 64'h100);
        chk("adv_exc", 64'(b0.ex_excepttype), 64'h8);
        chk("adv_exdly", 64'(b0.ex_is_in_delayslot), 64'd1);
        chk("adv_link", 64'(b0.ex_link_address), 64'h108);
        chk("adv_inst", 64'(b0.ex_inst), 64'h8c41_0004);
        chk("adv_dly_o", 64'(b0.is_in_delayslot_o), 64'd1);

        // ID stall: bubbles, counter climbs, feedback held
        b0.stall_id = 1; b0.next_inst_in_delayslot_i = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("bub_valid", 64'(b0.ex_valid), 64'd0);
            chk("bub_wreg", 64'(b0.ex_wreg), 64'd0);
            chk("bub_aluop", 64'(b0.ex_aluop), 64'd0);
            chk("bub_exc", 64'(b0.ex_excepttype), 64'd0);
            chk("bub_cnt", 64'(b0.bubble_cnt), 64'(i));
            chk("bub_dly_o", 64'(b0.is_in_delayslot_o), 64'd1);
        end

        // advance a fresh instruction, then hold it
        b0.stall_id = 0;
        b0.id_aluop = 8'h33; b0.id_reg2 = 32'hdead_beef;
        b0.id_wd = 5'd7; b0.next_inst_in_delayslot_i = 1;
        tick();
        chk("adv2_aluop", 64'(b0.ex_aluop), 64'h33);
        chk("adv2_cnt", 64'(b0.bubble_cnt), 64'd3);
        b0.stall_id = 1; b0.stall_ex = 1;
        b0.id_aluop = 8'h44; b0.id_reg2 = 32'h0; b0.id_wd = 5'd9;
        b0.next_inst_in_delayslot_i = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_aluop", 64'(b0.ex_aluop), 64'h33);
            chk("hold_reg2", 64'(b0.ex_reg2), 64'hdead_beef);
            chk("hold_wd", 64'(b0.ex_wd), 64'd7);
            chk("hold_valid", 64'(b0.ex_valid), 64'd1);
            chk("hold_cnt", 64'(b0.bubble_cnt), 64'd3);
            chk("hold_dly_o", 64'(b0.is_in_delayslot_o), 64'd1);
        end

        // flush beats stall
        b0.flush = 1;
        tick();
        chk("fl_valid", 64'(b0.ex_valid), 64'd0);
        chk("fl_dly_o", 64'(b0.is_in_delayslot_o), 64'd0);
        chk("fl_aluop", 64'(b0.ex_aluop), 64'd0);
        chk("fl_cnt", 64'(b0.bubble_cnt), 64'd3);

        // illegal stall_ex without stall_id still holds
        b0.flush = 0; b0.stall_ex = 0; b0.stall_id = 0;
        tick();
        chk("adv3_aluop", 64'(b0.ex_aluop), 64'h44);
        b0.stall_ex = 1; b0.id_aluop = 8'h55;
        tick();
        chk("exonly_aluop", 64'(b0.ex_aluop), 64'h44);
        chk("exonly_cnt", 64'(b0.bubble_cnt), 64'd3);

        // clear while advancing
        b0.stall_ex = 0; b0.cnt_clr = 1;
        tick();
        chk("clr_cnt", 64'(b0.bubble_cnt), 64'd0);
        chk("clr_aluop", 64'(b0.ex_aluop), 64'h55);
        b0.cnt_clr = 0;

        // async reset mid-stall
        b0.stall_ex = 1; b0.stall_id = 1;
        tick();
        chk("pre_rst_valid", 64'(b0.ex_valid), 64'd1);
        #2 rst = 0;
        #1;
        chk("arst_valid", 64'(b0.ex_valid), 64'd0);
        chk("arst_aluop", 64'(b0.ex_aluop), 64'd0);
        chk("arst_wd", 64'(b0.ex_wd), 64'd0);
        chk("arst_cnt", 64'(b0.bubble_cnt), 64'd0);
        #1 rst = 1;
        b0.stall_ex = 0; b0.stall_id = 0;
        tick();
        chk("post_rst_valid", 64'(b0.ex_valid), 64'd1);
        chk("post_rst_aluop", 64'(b0.ex_aluop), 64'h55);

        // 2-bit counter saturation on second instance
        b1.stall_id = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_cnt", 64'(b1.bubble_cnt), 64'(i > 3 ? 3 : i));
        end
        b1.cnt_clr = 1;
        tick();
        chk("sat_clr", 64'(b1.bubble_cnt), 64'd0);
        b1.cnt_clr = 0; b1.stall_id = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
